if_fetch: RTL

Instruction-fetch stage of the M0 pipeline. Sits directly upstream of the ID decoders: owns the program counter, issues one instruction-memory request at a time, and presents a registered instruction word with its PC and a valid flag to ID. Handles ID back-pressure (stall) through a one-entry buffer, and branch/jump redirects (flush) including discard of an in-flight stale response.

---
 rtl/if_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one memory request in flight, and
// presents a registered instruction to ID, with a one-entry stall buffer and flush redirect.
module if_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [31:0]       bufInst_q, bufInst_d;
  logic [ADDR_W-1:0] bufPc_q, bufPc_d;
  logic              bufValid_q, bufValid_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] instPc_q, instPc_d;
  logic              instValid_q, instValid_d;

  logic [ADDR_W-1:0] pcInc;
  logic [ADDR_W-1:0] flushTarget;

  assign pcInc       = pc_q + ADDR_W'(4);
  assign flushTarget = {flush_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      bufInst_q   <= '0;
      bufPc_q     <= '0;
      bufValid_q  <= 1'b0;
      inst_q      <= '0;
      instPc_q    <= '0;
      instValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      bufInst_q   <= bufInst_d;
      bufPc_q     <= bufPc_d;
      bufValid_q  <= bufValid_d;
      inst_q      <= inst_d;
      instPc_q    <= instPc_d;
      instValid_q <= instValid_d;
    end
  end

  // A valid word leaves the output when ID is not stalling; a load this cycle overrides that.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    bufInst_d   = bufInst_q;
    bufPc_d     = bufPc_q;
    bufValid_d  = bufValid_q;
    inst_d      = inst_q;
    instPc_d    = instPc_q;
    instValid_d = instValid_q && stall;

    if (flush) begin
      pc_d        = flushTarget;
      instValid_d = 1'b0;
      bufValid_d  = 1'b0;
      // A request already accepted at the old PC must have its response swallowed.
      if ((state_q == FETCH && imem_gnt) || (state_q == WAIT && !imem_rvalid)) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = FETCH;
        drop_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_gnt) begin
            state_d = WAIT;
            drop_d  = 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              state_d = FETCH;
              drop_d  = 1'b0;
            end else if (!instValid_q || !stall) begin
              inst_d      = imem_rdata;
              instPc_d    = pc_q;
              instValid_d = 1'b1;
              pc_d        = pcInc;
              state_d     = FETCH;
            end else begin
              bufInst_d  = imem_rdata;
              bufPc_d    = pc_q;
              bufValid_d = 1'b1;
              pc_d       = pcInc;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_d      = bufInst_q;
            instPc_d    = bufPc_q;
            instValid_d = bufValid_q;
            bufValid_d  = 1'b0;
            state_d     = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign imem_req   = rst && (state_q == FETCH);
  assign imem_addr  = rst ? pc_q : '0;
  assign inst       = inst_q;
  assign inst_pc    = instPc_q;
  assign inst_valid = instValid_q;

endmodule
